// File: rtl/vga_capture.sv
// vga_capture: samples a VGA-style pixel stream into a linear framebuffer.
// It frames on vsync and lines on the falling edge of valid. Odd lines can
// be stored mirrored (serpentine). Line and frame geometry errors are kept
// in sticky flags until err_clr, and clean frames are counted.
module vga_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SERPENTINE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        err_clr,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        err_line,
  output logic        err_frame,
  output logic        busy
);

  localparam int HW = $clog2(H_ACTIVE + 1);
  localparam int VW = $clog2(V_ACTIVE + 1);
  localparam logic [HW-1:0] H_MAX  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_MAX  = VW'(V_ACTIVE);
  localparam logic [18:0]   H_LAST = 19'(H_ACTIVE - 1);
  localparam logic [18:0]   H_W19  = 19'(H_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE
  } state_e;

  state_e        state_q, state_d;
  logic          hsync_q, vsync_q, valid_q;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          line_ovf_q, line_ovf_d;     // current line saw more than H_ACTIVE pixels
  logic          frame_bad_q, frame_bad_d;   // current frame had a line error
  logic          wr_en_q, wr_en_d;
  logic [18:0]   wr_addr_q, wr_addr_d;
  logic [23:0]   wr_data_q, wr_data_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          err_line_q, err_line_d;
  logic          err_frame_q, err_frame_d;
  logic          line_set, frame_set;

  logic          vs_fall, vs_rise, valid_fall;
  logic [18:0]   v_ext, h_ext, row_base, col, pix_addr;
  logic          mirror;

  assign vs_fall    = vsync_q & ~vsync;
  assign vs_rise    = ~vsync_q & vsync;
  assign valid_fall = valid_q & ~valid;

  // hsync is sampled for line monitoring only; nothing consumes it yet.
  logic unused_hsync_q;
  assign unused_hsync_q = hsync_q;

  // Framebuffer address: row base plus column, mirrored on odd rows.
  assign v_ext = 19'(v_cnt_q);
  assign h_ext = 19'(h_cnt_q);

  generate
    if (H_ACTIVE == 640) begin : g_row_shift
      assign row_base = (v_ext << 9) + (v_ext << 7);
    end else begin : g_row_mul
      assign row_base = v_ext * H_W19;
    end
  endgenerate

  assign mirror   = (SERPENTINE != 0) && v_cnt_q[0];
  assign col      = mirror ? (H_LAST - h_ext) : h_ext;
  assign pix_addr = row_base + col;

  // Next-state and output decode for the capture FSM and its counters.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    line_ovf_d   = line_ovf_q;
    frame_bad_d  = frame_bad_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_set     = 1'b0;
    frame_set    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (vs_fall && capture_en) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (vs_rise) begin
          state_d     = ST_ACTIVE;
          h_cnt_d     = '0;
          v_cnt_d     = '0;
          line_ovf_d  = 1'b0;
          frame_bad_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (vs_fall) begin
          state_d = capture_en ? ST_SYNC : ST_IDLE;
          if (v_cnt_q != V_MAX) begin
            frame_set = 1'b1;
          end else if (!frame_bad_q) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end
        end else if (valid) begin
          if (h_cnt_q < H_MAX && v_cnt_q < V_MAX) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr;
            wr_data_d = {vga_r, vga_g, vga_b};
          end
          // The counter saturates, so an overlong line is remembered
          // separately; otherwise it would look exactly H_ACTIVE long.
          if (h_cnt_q < H_MAX) h_cnt_d = h_cnt_q + HW'(1);
          else                 line_ovf_d = 1'b1;
        end else if (valid_fall) begin
          if (h_cnt_q != H_MAX || line_ovf_q) begin
            line_set    = 1'b1;
            frame_bad_d = 1'b1;
          end
          h_cnt_d    = '0;
          line_ovf_d = 1'b0;
          if (v_cnt_q < V_MAX) v_cnt_d = v_cnt_q + VW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Sticky flags: a set in the same cycle as err_clr wins.
    err_line_d  = line_set  | (err_line_q  & ~err_clr);
    err_frame_d = frame_set | (err_frame_q & ~err_clr);
  end

  // State, counter and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      valid_q      <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      line_ovf_q   <= 1'b0;
      frame_bad_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hsync_q      <= hsync;
      vsync_q      <= vsync;
      valid_q      <= valid;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      line_ovf_q   <= line_ovf_d;
      frame_bad_q  <= frame_bad_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;
  assign busy       = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: a small 8x4 instance exercises framing, errors,
// capture enable, reset and counter wrap; a 640-wide instance checks the
// default-width address arithmetic. Writes are scored against a queue of
// expected {addr,data} pushed as pixels are driven.
`timescale 1ns/1ps
module tb_vga_capture;

  localparam int HS = 8;
  localparam int VS = 4;
  localparam int HW = 640;
  localparam int VW = 2;

  logic        clk;
  logic        rst_s, rst_w;
  logic        capture_en, err_clr, hsync, vsync, valid;
  logic [7:0]  vga_r, vga_g, vga_b;

  logic        wr_en_s, frame_done_s, err_line_s, err_frame_s, busy_s;
  logic [18:0] wr_addr_s;
  logic [23:0] wr_data_s;
  logic [7:0]  frame_cnt_s;

  logic        wr_en_w, frame_done_w, err_line_w, err_frame_w, busy_w;
  logic [18:0] wr_addr_w;
  logic [23:0] wr_data_w;
  logic [7:0]  frame_cnt_w;

  vga_capture #(.H_ACTIVE(HS), .V_ACTIVE(VS), .SERPENTINE(1)) dut_s (
    .clk(clk), .reset(rst_s), .capture_en(capture_en), .err_clr(err_clr),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .frame_done(frame_done_s), .frame_cnt(frame_cnt_s),
    .err_line(err_line_s), .err_frame(err_frame_s), .busy(busy_s)
  );

  vga_capture #(.H_ACTIVE(HW), .V_ACTIVE(VW), .SERPENTINE(1)) dut_w (
    .clk(clk), .reset(rst_w), .capture_en(capture_en), .err_clr(err_clr),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
    .frame_done(frame_done_w), .frame_cnt(frame_cnt_w),
    .err_line(err_line_w), .err_frame(err_frame_w), .busy(busy_w)
  );

  typedef struct packed {
    logic [18:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t q_s[$];
  wr_t q_w[$];
  wr_t e_s, e_w;

  int  n_checks = 0;
  int  n_errors = 0;
  int  done_s   = 0;
  int  done_w   = 0;
  bit  exp_on   = 0;
  bit  use_w    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected address model: row-major, odd rows mirrored.
  function automatic int model_addr(input int v, input int h, input int hh);
    return v * hh + (((v % 2) == 1) ? (hh - 1 - h) : h);
  endfunction

  // Write monitors: pop the oldest expected write for every strobe seen.
  always @(negedge clk) begin
    if (wr_en_s) begin
      if (q_s.size() == 0) check("s_unexpected_wr", 1, 0);
      else begin
        e_s = q_s.pop_front();
        check("s_wr_addr", wr_addr_s, e_s.addr);
        check("s_wr_data", wr_data_s, e_s.data);
      end
    end
    if (wr_en_w) begin
      if (q_w.size() == 0) check("w_unexpected_wr", 1, 0);
      else begin
        e_w = q_w.pop_front();
        check("w_wr_addr", wr_addr_w, e_w.addr);
        check("w_wr_data", wr_data_w, e_w.data);
      end
    end
    if (frame_done_s) done_s++;
    if (frame_done_w) done_w++;
  end

  task automatic vsync_pulse();
    @(negedge clk) vsync = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk) vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_line(input int v, input int npix, input bit clr_at_end);
    int  hh, vv;
    wr_t e;
    hh = use_w ? HW : HS;
    vv = use_w ? VW : VS;
    @(negedge clk) hsync = 1'b0;
    @(negedge clk) hsync = 1'b1;
    for (int h = 0; h < npix; h++) begin
      @(negedge clk);
      valid = 1'b1;
      vga_r = 8'(h);
      vga_g = 8'(v);
      vga_b = 8'h5A;
      if (exp_on && h < hh && v < vv) begin
        e.addr = 19'(model_addr(v, h, hh));
        e.data = {8'(h), 8'(v), 8'h5A};
        if (use_w) q_w.push_back(e);
        else       q_s.push_back(e);
      end
    end
    @(negedge clk);
    valid   = 1'b0;
    err_clr = clr_at_end;
    vga_r   = 8'h00;
    vga_g   = 8'h00;
    vga_b   = 8'h00;
    @(negedge clk) err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input int nl, input int bad_v, input int bad_n, input bit clr);
    int hh;
    hh = use_w ? HW : HS;
    for (int v = 0; v < nl; v++)
      drive_line(v, (v == bad_v) ? bad_n : hh, clr && (v == bad_v));
  endtask

  task automatic pulse_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_s(input string pfx);
    check({pfx, "_wr_en"},      wr_en_s,      0);
    check({pfx, "_wr_addr"},    wr_addr_s,    0);
    check({pfx, "_wr_data"},    wr_data_s,    0);
    check({pfx, "_frame_done"}, frame_done_s, 0);
    check({pfx, "_frame_cnt"},  frame_cnt_s,  0);
    check({pfx, "_err_line"},   err_line_s,   0);
    check({pfx, "_err_frame"},  err_frame_s,  0);
    check({pfx, "_busy"},       busy_s,       0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_s = 1'b1; rst_w = 1'b1;
    capture_en = 1'b0; err_clr = 1'b0;
    hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
    vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_s("rst0");

    // Clean frame
    @(negedge clk) rst_s = 1'b0;
    capture_en = 1'b1;
    exp_on = 1;
    vsync_pulse();
    check("start_busy", busy_s, 1);
    d0 = done_s;
    run_frame(VS, -1, 0, 0);
    vsync_pulse();
    check("clean_done", done_s - d0, 1);
    check("clean_cnt", frame_cnt_s, 1);
    check("clean_err_line", err_line_s, 0);
    check("clean_err_frame", err_frame_s, 0);
    check("clean_drain", q_s.size(), 0);

    // Overlong line: excess pixel dropped, frame not counted
    d0 = done_s;
    run_frame(VS, 1, HS + 1, 0);
    vsync_pulse();
    check("long_err_line", err_line_s, 1);
    check("long_done", done_s - d0, 0);
    check("long_cnt", frame_cnt_s, 1);
    check("long_drain", q_s.size(), 0);
    pulse_clr();
    check("long_clr", err_line_s, 0);

    // Short frame, then recovery
    d0 = done_s;
    run_frame(VS - 1, -1, 0, 0);
    vsync_pulse();
    check("short_err_frame", err_frame_s, 1);
    check("short_done", done_s - d0, 0);
    check("short_cnt", frame_cnt_s, 1);
    d0 = done_s;
    run_frame(VS, -1, 0, 0);
    vsync_pulse();
    check("recover_done", done_s - d0, 1);
    check("recover_cnt", frame_cnt_s, 2);
    check("recover_sticky", err_frame_s, 1);
    pulse_clr();
    check("frame_clr", err_frame_s, 0);

    // Line error coinciding with err_clr: set wins
    d0 = done_s;
    run_frame(VS, 2, HS - 1, 1);
    vsync_pulse();
    check("setwin_err_line", err_line_s, 1);
    check("setwin_done", done_s - d0, 0);
    check("setwin_err_frame", err_frame_s, 0);
    pulse_clr();
    check("later_clr", err_line_s, 0);

    // capture_en dropped mid-frame: frame still completes, then idle
    d0 = done_s;
    for (int v = 0; v < VS; v++) begin
      if (v == 2) capture_en = 1'b0;
      drive_line(v, HS, 0);
    end
    vsync_pulse();
    check("cen_done", done_s - d0, 1);
    check("cen_cnt", frame_cnt_s, 3);
    check("cen_busy", busy_s, 0);
    exp_on = 0;
    d0 = done_s;
    run_frame(VS, -1, 0, 0);
    vsync_pulse();
    check("idle_busy", busy_s, 0);
    check("idle_cnt", frame_cnt_s, 3);
    check("idle_done", done_s - d0, 0);
    check("idle_drain", q_s.size(), 0);

    // Reset mid-frame
    capture_en = 1'b1;
    exp_on = 1;
    vsync_pulse();
    check("pre_rst_busy", busy_s, 1);
    drive_line(0, HS, 0);
    drive_line(1, HS, 0);
    @(negedge clk) rst_s = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_s("rst1");
    @(negedge clk) rst_s = 1'b0;
    @(negedge clk);
    check("post_rst_wr_en", wr_en_s, 0);
    check("post_rst_busy", busy_s, 0);
    exp_on = 0;
    drive_line(2, HS, 0);
    check("no_resume_busy", busy_s, 0);
    exp_on = 1;
    vsync_pulse();
    check("resume_busy", busy_s, 1);
    d0 = done_s;
    run_frame(VS, -1, 0, 0);
    vsync_pulse();
    check("resume_done", done_s - d0, 1);
    check("resume_cnt", frame_cnt_s, 1);

    // frame_cnt wrap 255 -> 0
    d0 = done_s;
    for (int f = 0; f < 254; f++) begin
      run_frame(VS, -1, 0, 0);
      vsync_pulse();
    end
    check("cnt_255", frame_cnt_s, 255);
    run_frame(VS, -1, 0, 0);
    vsync_pulse();
    check("cnt_wrap", frame_cnt_s, 0);
    check("wrap_done", done_s - d0, 255);
    check("wrap_drain", q_s.size(), 0);

    // Default-width address arithmetic on the 640-wide instance
    @(negedge clk) rst_s = 1'b1;
    use_w = 1;
    @(negedge clk) rst_w = 1'b0;
    vsync_pulse();
    d0 = done_w;
    run_frame(VW, -1, 0, 0);
    vsync_pulse();
    check("w_done", done_w - d0, 1);
    check("w_cnt", frame_cnt_w, 1);
    check("w_err_line", err_line_w, 0);
    check("w_err_frame", err_frame_w, 0);
    check("w_drain", q_w.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
